fifo_wr_arbiter: RTL

- Round-robin burst arbiter that shares one FIFO write port among N producers.
- Selects one requester at a time and holds the grant for up to MAX_BURST accepted beats.
- Drives the FIFO write-enable/data pair and honours the FIFO full flag.
- Sits between producer blocks and the FIFO write side (wen_a/din_a/full).

---
 rtl/fifo_wr_arbiter_if.sv | 13 +
 rtl/fifo_wr_arbiter.sv | 56 +++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request/data bundle plus FIFO write side of the arbiter
interface fifo_wr_arbiter_if #(parameter int N_REQ = 4, parameter int DATA_W = 16);
  logic [N_REQ-1:0] req;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0] gnt;
  logic fifo_full;
  logic fifo_wen;
  logic [DATA_W-1:0] fifo_din;
  logic busy;
  logic [$clog2(N_REQ)-1:0] owner;
  modport master (input req, din, fifo_full, output gnt, fifo_wen, fifo_din, busy, owner);
  modport slave (output req, din, fifo_full, input gnt, fifo_wen, fifo_din, busy, owner);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ producers
// FIFO_ARB_PRIO_EN: when defined, requester 0 wins every IDLE arbitration it requests in
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 16,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, pick, idx;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic beat, start;
  // descending scan so the nearest requester after owner_q is the last to overwrite pick
  always_comb begin
    pick = owner_q;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = OW'((int'(owner_q) + k) % N_REQ);
      if (bus.req[idx]) pick = idx;
    end
`ifdef FIFO_ARB_PRIO_EN
    if (bus.req[0]) pick = '0;
`endif
  end
  assign start = state_q == IDLE && |bus.req;
  assign beat = state_q == BURST && bus.req[owner_q] && !bus.fifo_full;
  always_comb begin
    state_d = state_q;
    owner_d = start ? pick : owner_q;
    beat_cnt_d = beat ? beat_cnt_q + 1'b1 : start ? '0 : beat_cnt_q;
    if (start) state_d = BURST;
    else if (state_q == BURST && (!bus.req[owner_q] || (beat && beat_cnt_q == CW'(MAX_BURST - 1)))) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OW'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
  assign bus.busy = state_q == BURST;
  assign bus.owner = owner_q;
  assign bus.fifo_wen = beat;
  assign bus.gnt = beat ? N_REQ'(1) << owner_q : '0;
  assign bus.fifo_din = state_q == BURST ? bus.din[int'(owner_q)*DATA_W +: DATA_W] : '0;
endmodule
